// File: rtl/uart_tx.sv
// 8N1 / 8N2 UART transmitter with a push-button request input.
// The request is a synchronized falling edge of send_n; one frame per press.
module uart_tx #(
    parameter int CLK_HZ    = 50000000,
    parameter int STOP_BITS = 1
) (
    input  logic       src_clk,
    input  logic       rst,
    input  logic [1:0] baud_sel,
    input  logic [7:0] data_in,
    input  logic       send_n,
    output logic       DataOut,
    output logic       busy,
    output logic       done
);

    localparam int DIV_9600   = CLK_HZ / 9600;
    localparam int DIV_57600  = CLK_HZ / 57600;
    localparam int DIV_115200 = CLK_HZ / 115200;
    localparam int CW         = $clog2(DIV_9600 + 1);

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_d;
    logic [1:0]    sync_q;
    logic [1:0]    sync_vld;
    logic          armed;
    logic          req;
    logic [CW-1:0] div_sel;
    logic [CW-1:0] div_q;
    logic [CW-1:0] cnt;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;
    logic          stop_idx;
    logic          bit_end;
    logic          line_d;

    // armed only follows a genuinely sampled high level, so a button held
    // through reset cannot masquerade as a fresh edge once reset drops
    always_ff @(posedge src_clk) begin
        if (rst) begin
            sync_q   <= 2'b11;
            sync_vld <= 2'b00;
            armed    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], send_n};
            sync_vld <= {sync_vld[0], 1'b1};
            armed    <= sync_vld[1] & sync_q[1];
        end
    end

    assign req = armed & ~sync_q[1];

    always_comb begin
        case (baud_sel)
            2'b01:   div_sel = CW'(DIV_57600);
            2'b10:   div_sel = CW'(DIV_115200);
            default: div_sel = CW'(DIV_9600);
        endcase
    end

    assign bit_end = (cnt == '0);
    assign busy    = (state != IDLE);

    always_comb begin
        state_d = state;
        done    = 1'b0;
        line_d  = 1'b1;
        case (state)
            IDLE:  if (req) state_d = START;
            START: begin
                line_d = 1'b0;
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                line_d = shreg[0];
                if (bit_end && bit_idx == 3'd7) state_d = STOP;
            end
            STOP: begin
                if (bit_end && stop_idx == STOP_LAST) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge src_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // DataOut is registered from the decoded line level, so it trails the
    // state register by one cycle but never glitches
    always_ff @(posedge src_clk) begin
        if (rst) begin
            DataOut  <= 1'b1;
            cnt      <= '0;
            div_q    <= '0;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else begin
            DataOut <= line_d;
            if (state == IDLE) begin
                if (req) begin
                    shreg    <= data_in;
                    div_q    <= div_sel;
                    cnt      <= div_sel - ONE;
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                end
            end else if (bit_end) begin
                cnt <= div_q - ONE;
                if (state == DATA) begin
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
                if (state == STOP) stop_idx <= ~stop_idx;
            end else begin
                cnt <= cnt - ONE;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a monitor
// decodes the serial line at bit centres and checks frame content and length.
module tb_uart_tx;

    localparam int CLK_HZ = 500000;  // divisors 52 / 8 / 4 keep runtime short

    logic       src_clk = 1'b0;
    logic       rst;
    logic [1:0] baud_sel;
    logic [7:0] data_in;
    logic       send_n;
    logic       DataOut;
    logic       busy;
    logic       done;

    uart_tx #(.CLK_HZ(CLK_HZ), .STOP_BITS(1)) dut (
        .src_clk  (src_clk),
        .rst      (rst),
        .baud_sel (baud_sel),
        .data_in  (data_in),
        .send_n   (send_n),
        .DataOut  (DataOut),
        .busy     (busy),
        .done     (done)
    );

    always #5 src_clk = ~src_clk;

    typedef struct {
        logic [7:0] data;
        int         div;
    } exp_t;

    exp_t exp_q[$];
    int   div_tbl[4] = '{52, 8, 4, 52};
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req_v);
        end
    endtask

    // ---------------- monitor ----------------
    logic       prev_line = 1'b1;
    bit         mon_on    = 0;
    bit         chk_busy  = 0;
    int         t, mdiv;
    logic [9:0] frm, mexp;

    always @(negedge src_clk) begin
        if (chk_busy) begin
            check("busy_after_done", busy, 0);
            chk_busy = 0;
        end
        if (rst) begin
            mon_on = 0;
        end else begin
            if (done) n_done++;
            if (mon_on) begin
                t++;
                if (t >= mdiv / 2 && (t - mdiv / 2) % mdiv == 0 && (t - mdiv / 2) / mdiv < 10)
                    frm[(t - mdiv / 2) / mdiv] = DataOut;
                if (done) begin
                    check("frame_bits", frm, mexp);
                    check("frame_len", t, 10 * mdiv - 2);
                    chk_busy = 1;
                    mon_on   = 0;
                end else if (t > 12 * mdiv) begin
                    check("frame_timeout", t, 10 * mdiv - 2);
                    mon_on = 0;
                end
            end else begin
                if (done) check("stray_done", done, 0);
                if (prev_line && !DataOut) begin
                    check("frame_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        exp_t e;
                        e      = exp_q.pop_front();
                        mdiv   = e.div;
                        mexp   = {1'b1, e.data, 1'b0};
                        frm    = 'x;
                        t      = 0;
                        mon_on = 1;
                    end
                end
            end
        end
        prev_line = DataOut;
    end

    // ---------------- stimulus ----------------
    // Call right after a negedge: queues the frame, presses, checks latency.
    task automatic press_frame(input logic [1:0] sel, input logic [7:0] d, input int hold);
        int lat;
        baud_sel = sel;
        data_in  = d;
        exp_q.push_back('{data: d, div: div_tbl[sel]});
        send_n = 1'b0;
        lat    = 0;
        while (DataOut !== 1'b0 && lat < 10) begin
            @(negedge src_clk);
            lat++;
        end
        check("start_latency", lat, 4);
        repeat (hold) @(negedge src_clk);
        send_n = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge src_clk);
            n++;
        end
        check("idle_timeout", busy, 0);
        repeat (4) @(negedge src_clk);
    endtask

    initial begin
        int d0;
        rst      = 1'b1;
        send_n   = 1'b0;  // held low through reset
        baud_sel = 2'b00;
        data_in  = 8'h00;
        repeat (3) @(negedge src_clk);
        check("reset_line", DataOut, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b0;
        repeat (30) @(negedge src_clk);
        check("held_low_after_reset", busy, 0);
        send_n = 1'b1;
        repeat (5) @(negedge src_clk);

        // 9600: 0x52 -> 0,0,1,0,0,1,0,1,0,1
        press_frame(2'b00, 8'h52, 5);
        wait_idle(800);
        // 115200: 0x5A
        press_frame(2'b10, 8'h5A, 5);
        wait_idle(100);
        // 57600: 0xA5
        press_frame(2'b01, 8'hA5, 5);
        wait_idle(200);
        // sel 11 behaves as 9600
        press_frame(2'b11, 8'h3C, 5);
        wait_idle(800);

        // held low across several frame times -> one frame only
        d0 = n_done;
        press_frame(2'b10, 8'h81, 150);
        wait_idle(100);
        check("held_low_one_frame", n_done - d0, 1);

        // second press while busy is dropped
        d0 = n_done;
        press_frame(2'b01, 8'h66, 3);
        repeat (10) @(negedge src_clk);
        send_n = 1'b0;
        repeat (3) @(negedge src_clk);
        send_n = 1'b1;
        wait_idle(200);
        repeat (10) @(negedge src_clk);
        check("busy_press_one_frame", n_done - d0, 1);

        // inputs change mid-frame; latched byte and rate must hold
        press_frame(2'b00, 8'hC3, 3);
        repeat (100) @(negedge src_clk);
        baud_sel = 2'b10;
        data_in  = 8'h00;
        wait_idle(800);

        // reset during data bit 4 (line time 40..47 at div 8)
        d0 = n_done;
        press_frame(2'b01, 8'hF0, 3);
        repeat (40) @(negedge src_clk);
        rst = 1'b1;
        @(negedge src_clk);
        check("abort_line", DataOut, 1);
        check("abort_busy", busy, 0);
        rst = 1'b0;
        repeat (20) @(negedge src_clk);
        check("abort_no_done", n_done - d0, 0);
        check("abort_queue_drained", exp_q.size(), 0);
        press_frame(2'b01, 8'h0F, 3);
        wait_idle(200);

        // request edge landing on the done cycle is ignored (done at t=38)
        d0 = n_done;
        press_frame(2'b10, 8'h33, 1);
        repeat (35) @(negedge src_clk);
        send_n = 1'b0;
        repeat (4) @(negedge src_clk);
        send_n = 1'b1;
        wait_idle(100);
        repeat (20) @(negedge src_clk);
        check("done_edge_no_frame", busy, 0);
        check("done_edge_one_frame", n_done - d0, 1);

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
